// File: rtl/wbm_arb.sv
// wbm_arb: two-requester Wishbone arbiter with alternating priority and strobe timeout
module wbm_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_cab_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_cab_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic        wbm_cab_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        g0, g1, term, tmo;
  // Grant decode, shared-bus mux and response routing to the owner only
  always_comb begin
    g0 = state_q == GNT0;
    g1 = state_q == GNT1;
    wbm_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    wbm_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    wbm_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    wbm_cab_o = g0 ? m0_cab_i : g1 ? m1_cab_i : 1'b0;
    wbm_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'd0;
    wbm_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : 32'd0;
    wbm_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : 32'd0;
    term = wbm_ack_i | wbm_err_i | wbm_rty_i;
    tmo = (g0 | g1) & wbm_stb_o & (cnt_q == 16'(TIMEOUT - 1));
    m0_dat_o = wbm_dat_i;
    m1_dat_o = wbm_dat_i;
    m0_ack_o = g0 & wbm_ack_i & ~tmo;
    m0_err_o = g0 & (wbm_err_i | tmo);
    m0_rty_o = g0 & wbm_rty_i;
    m1_ack_o = g1 & wbm_ack_i & ~tmo;
    m1_err_o = g1 & (wbm_err_i | tmo);
    m1_rty_o = g1 & wbm_rty_i;
    gnt_o = {g1, g0};
    timeout_o = tmo;
  end
  // Next grant, fairness memory and stall counter
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = (!(g0 | g1) || !wbm_stb_o || term || tmo) ? 16'd0 : cnt_q + 16'd1;
    if (state_q == IDLE) begin
      state_d = (m0_cyc_i & m1_cyc_i) ? (last_q ? GNT0 : GNT1) :
                m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    end else if (!(g0 ? m0_cyc_i : m1_cyc_i)) begin
      state_d = IDLE;
      last_d = g1;
      cnt_d = 16'd0;
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
